// File: rtl/glitch_seq_ctrl.sv
// Glitchy-clock sequencer: delay, then count glitch_en pulses of width, spaced by gap.
// Define GLITCH_SEQ_TRIG_EN to wait for a trig rising edge before the delay.
module glitch_seq_ctrl #(
  parameter int TW = 32,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic          trig,
  input  logic [TW-1:0] delay,
  input  logic [TW-1:0] width,
  input  logic [TW-1:0] gap,
  input  logic [PW-1:0] count,
  output logic          glitch_en,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] pulse_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_DELAY,
    S_GLITCH,
    S_GAP,
    S_DONE
  } st_e;

  localparam logic [TW-1:0] T1 = TW'(1);
  localparam logic [PW-1:0] P1 = PW'(1);

  st_e           st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] dly_q, dly_d;
  logic [TW-1:0] wid_q, wid_d;
  logic [TW-1:0] gap_q, gap_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          gen_q, gen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [TW-1:0] w_in_m1;
  logic [TW-1:0] w_sh_m1;
  logic          fire;

`ifdef GLITCH_SEQ_TRIG_EN
  logic trig_q;

  always_ff @(posedge clk) begin
    if (!rstn) trig_q <= 1'b0;
    else       trig_q <= trig;
  end

  assign fire = trig & ~trig_q;
`else
  logic unused_trig;
  assign unused_trig = trig;
  assign fire        = 1'b0;
`endif

  assign w_in_m1 = (width == '0) ? '0 : width - T1;
  assign w_sh_m1 = (wid_q == '0) ? '0 : wid_q - T1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q   <= S_IDLE;
      tmr_q  <= '0;
      dly_q  <= '0;
      wid_q  <= '0;
      gap_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      gen_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      dly_q  <= dly_d;
      wid_q  <= wid_d;
      gap_q  <= gap_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      gen_q  <= gen_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    dly_d = dly_q;
    wid_d = wid_q;
    gap_d = gap_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (abort) begin
      st_d = S_IDLE;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (start) begin
            dly_d = delay;
            wid_d = width;
            gap_d = gap;
            cnt_d = count;
            idx_d = '0;
            // zero-count runs pass one cycle through DELAY on the way to DONE
            if (count == '0) begin
              st_d  = S_DELAY;
              tmr_d = '0;
            end else begin
`ifdef GLITCH_SEQ_TRIG_EN
              st_d = S_ARM;
`else
              if (delay != '0) begin
                st_d  = S_DELAY;
                tmr_d = delay - T1;
              end else begin
                st_d  = S_GLITCH;
                tmr_d = w_in_m1;
              end
`endif
            end
          end
        end
`ifdef GLITCH_SEQ_TRIG_EN
        S_ARM: begin
          if (fire) begin
            if (dly_q != '0) begin
              st_d  = S_DELAY;
              tmr_d = dly_q - T1;
            end else begin
              st_d  = S_GLITCH;
              tmr_d = w_sh_m1;
            end
          end
        end
`endif
        S_DELAY: begin
          if (tmr_q == '0) begin
            if (cnt_q == '0) begin
              st_d = S_DONE;
            end else begin
              st_d  = S_GLITCH;
              tmr_d = w_sh_m1;
            end
          end else begin
            tmr_d = tmr_q - T1;
          end
        end
        S_GLITCH: begin
          if (tmr_q == '0) begin
            if (idx_q < cnt_q - P1) begin
              idx_d = idx_q + P1;
              if (gap_q != '0) begin
                st_d  = S_GAP;
                tmr_d = gap_q - T1;
              end else begin
                st_d  = S_GLITCH;
                tmr_d = w_sh_m1;
              end
            end else begin
              st_d = S_DONE;
            end
          end else begin
            tmr_d = tmr_q - T1;
          end
        end
        S_GAP: begin
          if (tmr_q == '0) begin
            st_d  = S_GLITCH;
            tmr_d = w_sh_m1;
          end else begin
            tmr_d = tmr_q - T1;
          end
        end
        S_DONE: begin
          st_d = S_IDLE;
        end
        default: begin
          st_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    gen_d  = (st_d == S_GLITCH);
    busy_d = (st_d != S_IDLE);
    done_d = (st_d == S_DONE);
  end

  assign glitch_en = gen_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_idx = idx_q;

endmodule

// File: tb/tb_glitch_seq_ctrl.sv
// Bench for glitch_seq_ctrl: directed and random runs checked against
// a timing model derived from delay/width/gap/count arithmetic.
module tb_glitch_seq_ctrl;

  localparam int TW = 32;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic          trig;
  logic [TW-1:0] delay;
  logic [TW-1:0] width;
  logic [TW-1:0] gap;
  logic [PW-1:0] count;
  logic          glitch_en;
  logic          busy;
  logic          done;
  logic [PW-1:0] pulse_idx;

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;

  int m_s, m_first, m_wp, m_p, m_n, m_e, m_kill, m_kind;

  always #5 clk = ~clk;

  glitch_seq_ctrl #(.TW(TW), .PW(PW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .trig      (trig),
    .delay     (delay),
    .width     (width),
    .gap       (gap),
    .count     (count),
    .glitch_en (glitch_en),
    .busy      (busy),
    .done      (done),
    .pulse_idx (pulse_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int base_idx(input int t);
    int k;
    if (m_n == 0 || t < m_first + m_wp) return 0;
    k = (t - m_first - m_wp) / m_p + 1;
    return (k < m_n - 1) ? k : m_n - 1;
  endfunction

  function automatic void model(input int t, output int g, output int b,
                                output int d, output int idx);
    if (m_n == 0) begin
      g = 0;
      b = (t == m_s + 1 || t == m_s + 2) ? 1 : 0;
      d = (t == m_s + 2) ? 1 : 0;
    end else begin
      b = (t >= m_s + 1 && t <= m_e) ? 1 : 0;
      d = (t == m_e) ? 1 : 0;
      g = (t >= m_first && t < m_e && ((t - m_first) % m_p) < m_wp) ? 1 : 0;
    end
    idx = base_idx(t);
    if (m_kill > 0 && t > m_kill) begin
      g = 0;
      b = 0;
      d = 0;
      idx = (m_kind == 2) ? 0 : base_idx(m_kill);
    end
  endfunction

  task automatic run(input int d, input int w, input int g, input int n,
                     input int tdel, input bit pre_hi,
                     input int kill_off, input int kind);
    int r;
    int t_end;
    delay = d;
    width = w;
    gap   = g;
    count = n;
    start = 1'b1;
    abort = 1'b0;
`ifdef GLITCH_SEQ_TRIG_EN
    trig = pre_hi;
`else
    trig = 1'($urandom_range(0, 1));
`endif
    m_s = cyc;
`ifdef GLITCH_SEQ_TRIG_EN
    r = m_s + tdel;
`else
    r = m_s;
`endif
    m_wp    = (w == 0) ? 1 : w;
    m_p     = m_wp + g;
    m_n     = n;
    m_first = r + 1 + d;
    m_e     = m_first + n * m_wp + (n - 1) * g;
    m_kill  = (kill_off > 0) ? r + kill_off : 0;
    m_kind  = kind;
    t_end   = (n == 0) ? m_s + 4 : m_e + 2;
    if (m_kill > 0 && m_kill + 3 < t_end) t_end = m_kill + 3;
    step();
    while (cyc <= t_end) begin
      int eg, eb, ed, ei;
      model(cyc, eg, eb, ed, ei);
      chk("glitch_en", 32'(glitch_en), eg);
      chk("busy", 32'(busy), eb);
      chk("done", 32'(done), ed);
      chk("pulse_idx", 32'(pulse_idx), ei);
      delay = $urandom;
      width = $urandom;
      gap   = $urandom;
      count = PW'($urandom);
      start = (eb != 0) && ($urandom_range(0, 3) == 0);
      abort = (kind == 1 && cyc == m_kill);
      rstn  = !(kind == 2 && cyc == m_kill);
`ifdef GLITCH_SEQ_TRIG_EN
      trig = (n != 0) && ((cyc >= r && cyc < r + 3) ||
                          (pre_hi && cyc < r - 1));
`else
      trig = 1'($urandom_range(0, 1));
`endif
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    rstn  = 1'b1;
    trig  = 1'b0;
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    trig  = 1'b0;
    delay = '0;
    width = '0;
    gap   = '0;
    count = '0;
    step();
    step();
    chk("rst_glitch_en", 32'(glitch_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pulse_idx", 32'(pulse_idx), 0);
    rstn = 1'b1;
    step();

    run(5, 3, 2, 1, 2, 1'b0, 0, 0);
    run(0, 2, 4, 3, 1, 1'b0, 0, 0);
    run(3, 0, 0, 2, 2, 1'b0, 0, 0);
    run(4, 3, 1, 0, 2, 1'b0, 0, 0);
    run(1, 2, 1, 2, 5, 1'b1, 0, 0);
    run(2, 2, 5, 3, 2, 1'b0, 6, 1);
    run(1, 4, 2, 2, 2, 1'b0, 3, 2);
    run(0, 1, 0, 1, 1, 1'b0, 0, 0);

    start = 1'b1;
    abort = 1'b1;
    count = 8'd2;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 0);
    chk("abort_start_glitch", 32'(glitch_en), 0);
    step();
    chk("abort_start_busy2", 32'(busy), 0);
    chk("abort_start_done", 32'(done), 0);

    for (int i = 0; i < 25; i++) begin
      int d, w, g, n, td, ko, kk;
      bit ph;
      d  = $urandom_range(0, 6);
      w  = $urandom_range(0, 4);
      g  = $urandom_range(0, 4);
      n  = $urandom_range(0, 4);
      td = $urandom_range(1, 5);
      ph = (td >= 3) && ($urandom_range(0, 1) == 1);
      ko = 0;
      kk = 0;
      if (n != 0 && $urandom_range(0, 3) == 0) begin
        kk = $urandom_range(1, 2);
        ko = $urandom_range(1, d + n * (w + 1 + g));
      end
      run(d, w, g, n, td, ph, ko, kk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
